adder_subtractor_checker: RTL and testbench
===========================================

// Module: adder_subtractor_checker
// PURPOSE
//  Response-side checker for the WIDTH-bit adder/subtractor: receives each applied vector
//  {subtract,A,B} with the DUT's Result/Cout, computes the golden value, and keeps
//  mismatch statistics over one exhaustive ordered sweep of 2^(2*WIDTH+1) vectors.
//  Sits opposite the sweep stimulus generator in the on-chip/self-checking test harness.
// PARAMETERS
//  WIDTH      4   operand width; sweep length N = 2^(2*WIDTH+1) (512 at default)
//  CNT_W      2*WIDTH+2   width of vector/error counters (holds N)
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        synchronous, active-high reset
//  start          in   1        pulse: arm a new sweep (ignored while busy)
//  in_valid       in   1        vector + DUT response present this cycle
//  in_subtract    in   1        applied mode: 0 add, 1 subtract
//  in_a           in   WIDTH    applied operand A
//  in_b           in   WIDTH    applied operand B
//  dut_result     in   WIDTH    DUT Result for this vector
//  dut_cout       in   1        DUT Cout for this vector
//  busy           out  1        sweep armed, vectors being accepted
//  done           out  1        1-cycle pulse when sweep completes
//  pass           out  1        sticky after done: 1 iff err_count==0 and seq_err==0
//  seq_err        out  1        sticky: a vector arrived out of sweep order
//  err_count      out  CNT_W    number of mismatching vectors in current sweep
//  vec_count      out  CNT_W    vectors accepted in current sweep
//  first_err_vld  out  1        first_err_* captured
//  first_err_vec  out  2W+1     {subtract,A,B} of first mismatch
//  first_err_got  out  WIDTH+1  {Cout,Result} from DUT at first mismatch
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; all outputs 0, counters 0, first_err_* 0.
//  Golden: add -> {Cout,Res} = A + B; sub -> {Cout,Res} = A + ~B + 1 (Cout=1 means no
//   borrow, A>=B); all arithmetic in WIDTH+1 bits, wrap mod 2^WIDTH on Res.
//  FSM IDLE -> RUN on start (clears counters, pass, seq_err, first_err_*; busy=1 next cycle).
//  RUN: each cycle with in_valid=1 accepts one vector; expected index = vec_count.
//   - {in_subtract,in_a,in_b} != vec_count[2W:0] -> seq_err set (vector still checked).
//   - {dut_cout,dut_result} != golden -> err_count+1; if !first_err_vld capture vec/got.
//   - vec_count+1. Counters/flags update on the same edge as acceptance (latency 1).
//  RUN -> DONE when the N-th vector is accepted; DONE lasts one cycle: done=1, busy=0,
//   pass = (err_count==0 && !seq_err) using the final-vector update. DONE -> IDLE.
//  IDLE/DONE: in_valid ignored, counters/flags hold (readable until next start).
//  start while RUN: ignored. start in DONE cycle: ignored (re-arm from IDLE).
//  err_count saturates at N (cannot wrap; N fits CNT_W).
//  rst mid-sweep: abort immediately to IDLE, all outputs 0, no done pulse.
//  Gaps (in_valid=0) in RUN are legal and stall the sweep indefinitely.
// STRUCTURE
//  Shared package adder_subtractor_pkg: WIDTH default, N, CNT_W, state encoding
//   (ST_IDLE, ST_RUN, ST_DONE), golden-function helper.
//  Sub-module addsub_golden (combinational, WIDTH param): {subtract,A,B} -> {Cout,Res}.
//  Top: FSM, vec/err counters, order comparator, first-error capture registers.
// TESTING
//  1 Correct DUT model, 512 back-to-back vectors 0..511 -> done pulse 1 cycle after
//    vector 511, pass=1, err_count=0, vec_count=512, seq_err=0.
//  2 Inject wrong Result at vector 9'h1A3 (sub,A=4'hA,B=4'h3; golden {1,4'h7}, send
//    {1,4'h6}) -> err_count=1, first_err_vec=9'h1A3, first_err_got=5'h16, pass=0.
//  3 Cout error only at add A=F,B=1 (vec 9'h0F1, golden {1,0}, send {0,0}) plus second
//    error later -> err_count=2, first_err_vec=9'h0F1 retained.
//  4 Swap order of vectors 5 and 6 with correct responses -> seq_err=1, err_count=0, pass=0.
//  5 Random in_valid gaps (~30%) over full sweep -> same final results as test 1, busy
//    held throughout, start pulses mid-sweep ignored.
//  6 rst asserted after 100 vectors -> next cycle all outputs 0, no done; restart with
//    start, full sweep -> pass=1.

Source files
------------

// File: rtl/adder_subtractor_pkg.sv
// Shared constants, FSM encoding and golden add/sub helper for the adder/subtractor
// response checker.
package adder_subtractor_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 2 * WIDTH_DEF + 2;
  localparam int unsigned N_DEF     = 2 ** (2 * WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Subtract is A + ~B + 1, so Cout=1 means no borrow (A >= B).
  function automatic logic [WIDTH_DEF:0] golden_addsub(input logic                 sub,
                                                       input logic [WIDTH_DEF-1:0] a,
                                                       input logic [WIDTH_DEF-1:0] b);
    return {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH_DEF{1'b0}}, sub};
  endfunction

endpackage

// File: rtl/addsub_golden.sv
// Combinational golden model of the WIDTH-bit adder/subtractor: {sub,A,B} -> {Cout,Res}.
module addsub_golden #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             subtract_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   result_o
);

  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff    = subtract_i ? ~b_i : b_i;
    result_o = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract_i};
  end

endmodule

// File: rtl/adder_subtractor_checker.sv
// Response-side checker: scores one ordered exhaustive sweep of {sub,A,B} vectors against
// the golden add/sub function and keeps mismatch statistics.
module adder_subtractor_checker
  import adder_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 2 * WIDTH + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic               in_subtract,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH-1:0]   dut_result,
  input  logic               dut_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               seq_err,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   vec_count,
  output logic               first_err_vld,
  output logic [2*WIDTH:0]   first_err_vec,
  output logic [WIDTH:0]     first_err_got
);

  localparam int unsigned     VecW    = 2 * WIDTH + 1;
  localparam int unsigned     NVec    = 2 ** VecW;
  localparam logic [CNT_W-1:0] NCnt    = CNT_W'(NVec);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NVec - 1);

  state_e           state_q, state_d;
  logic             pass_q, pass_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic             first_err_vld_q, first_err_vld_d;
  logic [VecW-1:0]  first_err_vec_q, first_err_vec_d;
  logic [WIDTH:0]   first_err_got_q, first_err_got_d;

  logic [VecW-1:0]  in_vec;
  logic [WIDTH:0]   got;
  logic [WIDTH:0]   golden;
  logic             mismatch;
  logic             out_of_order;

  addsub_golden #(
    .WIDTH(WIDTH)
  ) u_golden (
    .subtract_i(in_subtract),
    .a_i       (in_a),
    .b_i       (in_b),
    .result_o  (golden)
  );

  always_comb begin
    in_vec       = {in_subtract, in_a, in_b};
    got          = {dut_cout, dut_result};
    mismatch     = (got != golden);
    out_of_order = (in_vec != vec_count_q[VecW-1:0]);
  end

  always_comb begin
    state_d         = state_q;
    pass_d          = pass_q;
    seq_err_d       = seq_err_q;
    err_count_d     = err_count_q;
    vec_count_d     = vec_count_q;
    first_err_vld_d = first_err_vld_q;
    first_err_vec_d = first_err_vec_q;
    first_err_got_d = first_err_got_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d         = ST_RUN;
          pass_d          = 1'b0;
          seq_err_d       = 1'b0;
          err_count_d     = '0;
          vec_count_d     = '0;
          first_err_vld_d = 1'b0;
          first_err_vec_d = '0;
          first_err_got_d = '0;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          vec_count_d = vec_count_q + CNT_W'(1);
          if (out_of_order) seq_err_d = 1'b1;
          if (mismatch) begin
            if (err_count_q != NCnt) err_count_d = err_count_q + CNT_W'(1);
            if (!first_err_vld_q) begin
              first_err_vld_d = 1'b1;
              first_err_vec_d = in_vec;
              first_err_got_d = got;
            end
          end
          // Verdict must include the final vector's own update.
          if (vec_count_q == LastCnt) begin
            state_d = ST_DONE;
            pass_d  = (err_count_d == '0) && !seq_err_d;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pass_q          <= 1'b0;
      seq_err_q       <= 1'b0;
      err_count_q     <= '0;
      vec_count_q     <= '0;
      first_err_vld_q <= 1'b0;
      first_err_vec_q <= '0;
      first_err_got_q <= '0;
    end else begin
      state_q         <= state_d;
      pass_q          <= pass_d;
      seq_err_q       <= seq_err_d;
      err_count_q     <= err_count_d;
      vec_count_q     <= vec_count_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_vec_q <= first_err_vec_d;
      first_err_got_q <= first_err_got_d;
    end
  end

  always_comb begin
    busy          = (state_q == ST_RUN);
    done          = (state_q == ST_DONE);
    pass          = pass_q;
    seq_err       = seq_err_q;
    err_count     = err_count_q;
    vec_count     = vec_count_q;
    first_err_vld = first_err_vld_q;
    first_err_vec = first_err_vec_q;
    first_err_got = first_err_got_q;
  end

endmodule

// File: tb/tb_adder_subtractor_checker.sv
// Randomised self-checking bench for adder_subtractor_checker with a behavioural model.
module tb_adder_subtractor_checker;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_subtract, dut_cout;
  logic [3:0] in_a, in_b, dut_result;
  logic       busy, done, pass, seq_err, first_err_vld;
  logic [9:0] err_count, vec_count;
  logic [8:0] first_err_vec;
  logic [4:0] first_err_got;

  int checks   = 0;
  int failures = 0;

  adder_subtractor_checker #(
    .WIDTH(4),
    .CNT_W(10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_subtract  (in_subtract),
    .in_a         (in_a),
    .in_b         (in_b),
    .dut_result   (dut_result),
    .dut_cout     (dut_cout),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .seq_err      (seq_err),
    .err_count    (err_count),
    .vec_count    (vec_count),
    .first_err_vld(first_err_vld),
    .first_err_vec(first_err_vec),
    .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  // Golden from plain arithmetic: add gives a 5-bit sum; subtract gives no-borrow flag + diff.
  function automatic logic [4:0] gold(input logic [8:0] v);
    int a, b;
    a = int'(v[7:4]);
    b = int'(v[3:0]);
    if (!v[8]) return 5'(a + b);
    return {(a >= b) ? 1'b1 : 1'b0, 4'((a - b) & 15)};
  endfunction

  // Behavioural model: phase 0 idle, 1 running, 2 done cycle.
  int         m_phase = 0;
  bit         m_init  = 0;
  int         m_vec, m_err;
  bit         m_pass, m_seq, m_fv;
  logic [8:0] m_fvec;
  logic [4:0] m_fgot;

  always @(posedge clk) begin
    logic [8:0] v;
    logic [4:0] r;
    if (rst) begin
      m_init = 1; m_phase = 0; m_vec = 0; m_err = 0;
      m_pass = 0; m_seq = 0; m_fv = 0; m_fvec = '0; m_fgot = '0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_vec = 0; m_err = 0;
        m_pass = 0; m_seq = 0; m_fv = 0; m_fvec = '0; m_fgot = '0;
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        v = {in_subtract, in_a, in_b};
        r = {dut_cout, dut_result};
        if (int'(v) != m_vec) m_seq = 1;
        if (r != gold(v)) begin
          if (m_err < 512) m_err++;
          if (!m_fv) begin m_fv = 1; m_fvec = v; m_fgot = r; end
        end
        m_vec++;
        if (m_vec == 512) begin
          m_phase = 2;
          m_pass  = (m_err == 0) && !m_seq;
        end
      end
    end else begin
      m_phase = 0;
    end
  end

  // Per-cycle comparison of the whole output bundle against the model.
  always @(negedge clk) begin
    logic [39:0] got_b, exp_b;
    if (m_init) begin
      got_b = {busy, done, pass, seq_err, err_count, vec_count, first_err_vld,
               first_err_vec, first_err_got};
      exp_b = {(m_phase == 1), (m_phase == 2), m_pass, m_seq, 10'(m_err), 10'(m_vec), m_fv,
               m_fvec, m_fgot};
      checks++;
      if (got_b !== exp_b) begin
        failures++;
        $display("FAIL model_cycle t=%0t got=%h exp=%h", $time, got_b, exp_b);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] v, input int mode);
    logic [4:0] r;
    r = gold(v);
    if (mode == 2 && v == 9'h1A3) r = 5'h16;
    if (mode == 3 && v == 9'h0F1) r = 5'h00;
    if (mode == 3 && v == 9'h155) r = r ^ 5'h01;
    in_valid = 1'b1;
    {in_subtract, in_a, in_b} = v;
    {dut_cout, dut_result} = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends the first n vectors in order (optionally swapping 5/6), with random idle gaps.
  task automatic sweep(input int mode, input int gap_pct, input bit swap, input int n);
    logic [8:0] v;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        {in_subtract, in_a, in_b} = 9'($urandom);
        {dut_cout, dut_result} = 5'($urandom);
        start = ($urandom_range(3) == 0);
        tick();
        start = 1'b0;
      end
      v = 9'(i);
      if (swap && i == 5) v = 9'd6;
      if (swap && i == 6) v = 9'd5;
      send(v, mode);
    end
  endtask

  task automatic end_of_sweep(input string tag);
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    tick();
    chk({tag, "_done_fall"}, 16'(done), 16'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_subtract = 1'b0; in_a = '0; in_b = '0; dut_result = '0; dut_cout = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", {busy, done, pass, seq_err, 12'(err_count | vec_count)}, 16'h0);

    // Clean sweep.
    arm();
    chk("busy_after_start", 16'(busy), 16'd1);
    sweep(0, 0, 1'b0, 512);
    end_of_sweep("t1");
    chk("t1_pass", 16'(pass), 16'd1);
    chk("t1_vec", 16'(vec_count), 16'd512);
    chk("t1_err", 16'(err_count), 16'd0);

    // Wrong Result on one subtract vector.
    arm();
    sweep(2, 0, 1'b0, 512);
    end_of_sweep("t2");
    chk("t2_err", 16'(err_count), 16'd1);
    chk("t2_fvec", 16'(first_err_vec), 16'h1A3);
    chk("t2_fgot", 16'(first_err_got), 16'h16);
    chk("t2_pass", 16'(pass), 16'd0);

    // Cout-only error then a later error; first capture retained.
    arm();
    sweep(3, 0, 1'b0, 512);
    end_of_sweep("t3");
    chk("t3_err", 16'(err_count), 16'd2);
    chk("t3_fvec", 16'(first_err_vec), 16'h0F1);
    chk("t3_fgot", 16'(first_err_got), 16'h00);

    // Out-of-order vectors with correct responses.
    arm();
    sweep(0, 0, 1'b1, 512);
    end_of_sweep("t4");
    chk("t4_seq", 16'(seq_err), 16'd1);
    chk("t4_err", 16'(err_count), 16'd0);
    chk("t4_pass", 16'(pass), 16'd0);

    // Random gaps and stray start pulses mid-sweep.
    arm();
    sweep(0, 30, 1'b0, 512);
    end_of_sweep("t5");
    chk("t5_pass", 16'(pass), 16'd1);
    chk("t5_vec", 16'(vec_count), 16'd512);

    // Abort mid-sweep, then a full clean sweep.
    arm();
    sweep(0, 0, 1'b0, 100);
    chk("t6_vec_before", 16'(vec_count), 16'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_abort", {busy, done, pass, seq_err, first_err_vld, 11'(err_count | vec_count)},
        16'h0);
    tick(); tick();
    chk("t6_no_done", 16'(done), 16'd0);
    arm();
    sweep(0, 0, 1'b0, 512);
    end_of_sweep("t6");
    chk("t6_pass", 16'(pass), 16'd1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
